// File: rtl/pixel_uart_pkg.sv
// Shared types and defaults for the pixel UART send path and the frame-buffer receive path.
package pixel_uart_pkg;

    localparam int unsigned NUM_PIXELS_DEF = 200000;
    localparam int unsigned ADDR_W_DEF     = 18;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned PIXEL_W        = 24;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_LATCH  = 3'd2,
        ST_SEND_R = 3'd3,
        ST_SEND_G = 3'd4,
        ST_SEND_B = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    // Frame-buffer word layout: blue in the top byte, red in the bottom byte.
    typedef struct packed {
        logic [BYTE_W-1:0] b;
        logic [BYTE_W-1:0] g;
        logic [BYTE_W-1:0] r;
    } pixel_t;

endpackage

// File: rtl/pixel_uart_sender.sv
// Streams a frame buffer to a byte-level UART transmitter as R,G,B bytes per word,
// one read per pixel, with a done pulse once the last byte of the frame is accepted.
module pixel_uart_sender
    import pixel_uart_pkg::*;
#(
    parameter int unsigned NUM_PIXELS = NUM_PIXELS_DEF,
    parameter int unsigned ADDR_W     = ADDR_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [PIXEL_W-1:0] rd_data,
    input  logic               tx_ready,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  addr,
    output logic               tx_valid,
    output logic [BYTE_W-1:0]  tx_data,
    output logic               busy,
    output logic               done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   addr_next;
    pixel_t              pixel;
    pixel_t              pixel_next;
    logic                xfer_c;

    logic                rd_en_d;
    logic                tx_valid_d;
    logic [BYTE_W-1:0]   tx_data_d;
    logic                busy_d;
    logic                done_d;

    assign xfer_c = tx_valid & tx_ready;

    // State, address and pixel registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            addr  <= '0;
            pixel <= '0;
        end else begin
            state <= state_next;
            addr  <= addr_next;
            pixel <= pixel_next;
        end
    end

    // Next-state, address and pixel capture.
    always_comb begin
        state_next = state;
        addr_next  = addr;
        pixel_next = pixel;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_READ;
                end
            end
            ST_READ: begin
                state_next = ST_LATCH;
            end
            ST_LATCH: begin
                pixel_next = pixel_t'(rd_data);
                state_next = ST_SEND_R;
            end
            ST_SEND_R: begin
                if (xfer_c) begin
                    state_next = ST_SEND_G;
                end
            end
            ST_SEND_G: begin
                if (xfer_c) begin
                    state_next = ST_SEND_B;
                end
            end
            ST_SEND_B: begin
                if (xfer_c) begin
                    if (addr == LAST_ADDR) begin
                        state_next = ST_DONE;
                    end else begin
                        addr_next  = addr + ADDR_W'(1);
                        state_next = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                addr_next  = '0;
                state_next = ST_IDLE;
            end
            default: begin
                addr_next  = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the upcoming state so the registered copies line up with it.
    always_comb begin
        rd_en_d    = 1'b0;
        tx_valid_d = 1'b0;
        tx_data_d  = '0;
        busy_d     = (state_next != ST_IDLE);
        done_d     = 1'b0;
        case (state_next)
            ST_READ: begin
                rd_en_d = 1'b1;
            end
            ST_SEND_R: begin
                tx_valid_d = 1'b1;
                tx_data_d  = pixel_next.r;
            end
            ST_SEND_G: begin
                tx_valid_d = 1'b1;
                tx_data_d  = pixel_next.g;
            end
            ST_SEND_B: begin
                tx_valid_d = 1'b1;
                tx_data_d  = pixel_next.b;
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                rd_en_d = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en    <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            rd_en    <= rd_en_d;
            tx_valid <= tx_valid_d;
            tx_data  <= tx_data_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

endmodule

// File: tb/tb_pixel_uart_sender.sv
// Bench for pixel_uart_sender: three frame sizes checked every cycle against a model that
// derives expected outputs from the frame position (5 cycles per pixel, stalls freeze it).
`timescale 1ns/1ps
module tb_pixel_uart_sender;

    localparam int NI = 3;
    localparam int NP [NI] = '{4, 1, 8};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_v    [NI];
    logic        start_v    [NI];
    logic        ready_v    [NI];
    logic [23:0] rd_data_v  [NI];
    logic        o_rd_en    [NI];
    logic        o_tx_valid [NI];
    logic [7:0]  o_tx_data  [NI];
    logic        o_busy     [NI];
    logic        o_done     [NI];
    int unsigned o_addr     [NI];
    logic [17:0] addr0;
    logic [3:0]  addr1;
    logic [2:0]  addr2;

    assign o_addr[0] = 32'(addr0);
    assign o_addr[1] = 32'(addr1);
    assign o_addr[2] = 32'(addr2);

    pixel_uart_sender #(.NUM_PIXELS(4), .ADDR_W(18)) u_dut0 (
        .clk(clk), .rst_n(rst_n_v[0]), .start(start_v[0]), .rd_data(rd_data_v[0]),
        .tx_ready(ready_v[0]), .rd_en(o_rd_en[0]), .addr(addr0), .tx_valid(o_tx_valid[0]),
        .tx_data(o_tx_data[0]), .busy(o_busy[0]), .done(o_done[0]));

    pixel_uart_sender #(.NUM_PIXELS(1), .ADDR_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n_v[1]), .start(start_v[1]), .rd_data(rd_data_v[1]),
        .tx_ready(ready_v[1]), .rd_en(o_rd_en[1]), .addr(addr1), .tx_valid(o_tx_valid[1]),
        .tx_data(o_tx_data[1]), .busy(o_busy[1]), .done(o_done[1]));

    pixel_uart_sender #(.NUM_PIXELS(8), .ADDR_W(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n_v[2]), .start(start_v[2]), .rd_data(rd_data_v[2]),
        .tx_ready(ready_v[2]), .rd_en(o_rd_en[2]), .addr(addr2), .tx_valid(o_tx_valid[2]),
        .tx_data(o_tx_data[2]), .busy(o_busy[2]), .done(o_done[2]));

    logic [23:0] key [NI];
    int          me [NI];
    logic [7:0]  got [NI][$];
    int          done_cnt [NI];
    int          n_tests = 0;
    int          n_fail  = 0;
    string       lq_n [$];
    int unsigned lq_g [$];
    int unsigned lq_e [$];

    function automatic logic [23:0] mem_word(input int i, input int a);
        return (24'hB06040 + 24'(a) * 24'h010101) ^ key[i];
    endfunction

    function automatic string nm(input string b, input int i);
        return $sformatf("%s[%0d]", b, i);
    endfunction

    task automatic chk(input string name, input int unsigned act, input int unsigned req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic lit(input string name, input int unsigned act, input int unsigned req);
        lq_n.push_back(name);
        lq_g.push_back(act);
        lq_e.push_back(req);
    endtask

    // Frame buffer with one cycle of read latency.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (o_rd_en[i]) rd_data_v[i] <= mem_word(i, int'(o_addr[i]));
        end
    end

    // Position e counts non-stalled cycles since start: pixel p owns e=5p+1..5p+5
    // (read, latch, R, G, B), e=5N+1 is the done cycle, e=0 is idle.
    task automatic model_step(input int i);
        int n, e, p, s;
        logic [23:0] w;
        logic x_rd, x_val, x_busy, x_done;
        int unsigned x_addr;
        logic [7:0] x_data;
        n = NP[i]; e = me[i];
        x_rd = 1'b0; x_val = 1'b0; x_busy = 1'b0; x_done = 1'b0; x_addr = 0; x_data = 8'h00;
        if (rst_n_v[i]) begin
            x_busy = (e != 0);
            x_done = (e == 5 * n + 1);
            if (e >= 1 && e <= 5 * n) begin
                p = (e - 1) / 5;
                s = (e - 1) % 5;
                x_rd   = (s == 0);
                x_val  = (s >= 2);
                x_addr = 32'(p);
                w = mem_word(i, p);
                if (s == 2)      x_data = w[7:0];
                else if (s == 3) x_data = w[15:8];
                else             x_data = w[23:16];
            end else if (e != 0) begin
                x_addr = 32'(n - 1);
            end
        end
        chk(nm("rd_en", i), o_rd_en[i], x_rd);
        chk(nm("tx_valid", i), o_tx_valid[i], x_val);
        chk(nm("busy", i), o_busy[i], x_busy);
        chk(nm("done", i), o_done[i], x_done);
        chk(nm("addr", i), o_addr[i], x_addr);
        if (x_val || !rst_n_v[i]) chk(nm("tx_data", i), o_tx_data[i], x_data);
        if (rst_n_v[i] && o_tx_valid[i] && ready_v[i]) got[i].push_back(o_tx_data[i]);
        if (rst_n_v[i] && o_done[i]) done_cnt[i]++;
        if (!rst_n_v[i]) e = 0;
        else if (e == 0) e = start_v[i] ? 1 : 0;
        else if (!(x_val && !ready_v[i])) e = (e == 5 * n + 1) ? 0 : e + 1;
        me[i] = e;
    endtask

    // Single compare process: queued literal checks, then the per-cycle model.
    always @(negedge clk) begin
        while (lq_n.size() > 0) chk(lq_n.pop_front(), lq_g.pop_front(), lq_e.pop_front());
        for (int i = 0; i < NI; i++) model_step(i);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int i, input bit rnd, input int s1, input int s2,
                             input int st_from, input int st_len,
                             output int cyc, output int gb, output int db);
        int budget;
        budget = 40 * NP[i] + 50;
        gb = got[i].size();
        db = done_cnt[i];
        start_v[i] = 1'b1;
        tick();
        cyc = 1;
        forever begin
            start_v[i] = (cyc == s1) || (cyc == s2);
            if (rnd) ready_v[i] = ($urandom_range(0, 3) != 0);
            else     ready_v[i] = !(cyc >= st_from && cyc < st_from + st_len);
            @(negedge clk);
            if (o_done[i]) break;
            if (cyc >= budget) begin
                lit(nm("done_seen", i), 32'(o_done[i]), 1);
                break;
            end
            tick();
            cyc++;
        end
        tick();
        start_v[i] = 1'b0;
        ready_v[i] = 1'b1;
        tick();
    endtask

    task automatic frame_check(input int i, input int gb, input int db);
        lit(nm("bytes_sent", i), 32'(got[i].size() - gb), 32'(3 * NP[i]));
        lit(nm("done_pulses", i), 32'(done_cnt[i] - db), 1);
        lit(nm("busy_after", i), 32'(o_busy[i]), 0);
    endtask

    initial begin
        int cyc, gb, db;
        for (int i = 0; i < NI; i++) begin
            rst_n_v[i] = 1'b0; start_v[i] = 1'b0; ready_v[i] = 1'b1; key[i] = 24'h0;
        end
        repeat (3) tick();
        lit("reset_busy", 32'(o_busy[0]), 0);
        lit("reset_tx_valid", 32'(o_tx_valid[0]), 0);
        for (int i = 0; i < NI; i++) rst_n_v[i] = 1'b1;
        repeat (2) tick();

        // Four pixels, transmitter always ready.
        run_frame(0, 1'b0, 0, 0, 0, 0, cyc, gb, db);
        frame_check(0, gb, db);
        lit("frame_cycles_n4", 32'(cyc), 21);
        lit("byte0_r0", 32'(got[0][gb]), 32'h40);
        lit("byte4_g1", 32'(got[0][gb + 4]), 32'h61);
        lit("byte11_b3", 32'(got[0][gb + 11]), 32'hB3);

        // Seven-cycle stall while the first G byte is presented.
        run_frame(0, 1'b0, 0, 0, 4, 7, cyc, gb, db);
        frame_check(0, gb, db);
        lit("frame_cycles_stall", 32'(cyc), 28);
        lit("stall_byte1_g0", 32'(got[0][gb + 1]), 32'h60);

        // Start re-pulsed mid-frame and during the done cycle.
        run_frame(0, 1'b0, 7, 21, 0, 0, cyc, gb, db);
        frame_check(0, gb, db);
        lit("frame_cycles_restart", 32'(cyc), 21);
        repeat (3) tick();
        lit("no_restart_busy", 32'(o_busy[0]), 0);

        // Reset during SEND_B of pixel 2, then a clean frame from address 0.
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        repeat (14) tick();
        @(negedge clk);
        lit("pre_reset_tx_valid", 32'(o_tx_valid[0]), 1);
        lit("pre_reset_tx_data", 32'(o_tx_data[0]), 32'hB2);
        #2 rst_n_v[0] = 1'b0;
        #1;
        lit("async_rd_en", 32'(o_rd_en[0]), 0);
        lit("async_tx_valid", 32'(o_tx_valid[0]), 0);
        lit("async_tx_data", 32'(o_tx_data[0]), 0);
        lit("async_busy", 32'(o_busy[0]), 0);
        lit("async_done", 32'(o_done[0]), 0);
        lit("async_addr", o_addr[0], 0);
        repeat (3) tick();
        rst_n_v[0] = 1'b1;
        repeat (4) tick();
        lit("post_reset_idle", 32'(o_busy[0]), 0);
        run_frame(0, 1'b0, 0, 0, 0, 0, cyc, gb, db);
        frame_check(0, gb, db);
        lit("frame_cycles_after_reset", 32'(cyc), 21);
        lit("after_reset_byte0", 32'(got[0][gb]), 32'h40);

        // Single-pixel frame and a frame that fills the whole address space.
        run_frame(1, 1'b0, 0, 0, 0, 0, cyc, gb, db);
        frame_check(1, gb, db);
        lit("frame_cycles_n1", 32'(cyc), 6);
        lit("n1_byte2_b0", 32'(got[1][gb + 2]), 32'hB0);
        run_frame(2, 1'b0, 0, 0, 0, 0, cyc, gb, db);
        frame_check(2, gb, db);
        lit("frame_cycles_n8", 32'(cyc), 41);
        lit("n8_byte23_b7", 32'(got[2][gb + 23]), 32'hB7);

        // Random memory contents and random transmitter back-pressure.
        for (int r = 0; r < 12; r++) begin
            int i;
            i = r % NI;
            key[i] = 24'($urandom);
            run_frame(i, 1'b1, 0, 0, 0, 0, cyc, gb, db);
            frame_check(i, gb, db);
            repeat ($urandom_range(0, 3)) tick();
        end

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
